scd_lsu: RTL and testbench
==========================

Name: scd_lsu

Overview:
- Load/store initiator between the single-cycle CPU datapath and the word-wide registered data memory.
- Converts CPU byte, halfword and word loads and stores into word-only memory transactions.
- Sub-word stores use read-modify-write.
- Waits out the memory's registered read latency and returns sign- or zero-extended load data.
- Flags misaligned accesses to the interrupt/exception logic.

Parameters:
- RD_LAT, 2, memory cycles from a stable mem_addr to valid mem_dataout (registered address plus registered output). Legal range 1..7.
- AW, 32, CPU address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clrn  in  1  asynchronous, active-low reset.
- req  in  1  CPU access request; sampled only while busy=0.
- wr  in  1  1=store, 0=load; qualified by req.
- size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as word).
- sext  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-aligned.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result; held until the next load completes.
- misalign  out  1  one-cycle pulse on a misaligned request.
- mem_addr  out  AW  word address to memory; addr with bits [1:0] forced to 00.
- mem_datain  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_dataout  in  32  read data from memory.

Behaviour:
- Reset: state=IDLE; busy, done, misalign, mem_we = 0; rdata, mem_addr, mem_datain = 0; latency counter = 0.
- Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0], addr[1:0]=3 selects bits [31:24]. Halfword addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
- Misaligned request: halfword with addr[0]=1, or word with addr[1:0]≠0.
- State machine: IDLE, RD, WR, DONE.
  - IDLE: on req=1 the block registers addr, wr, size, sext and wdata, then drives mem_addr. Next state:
    - load → RD
    - word store → WR
    - sub-word store → RD
  - RD: holds mem_addr stable and counts RD_LAT cycles. On the last count edge it captures mem_dataout, then:
    - load: extracts the lane, extends to 32 bits into rdata, goes to DONE.
    - sub-word store: merges wdata's low byte or halfword into the captured word, goes to WR.
  - WR: mem_we=1 for exactly one full cycle; mem_addr and mem_datain are stable for the whole cycle. Next state DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- req while busy is ignored; the CPU holds req until done.
- Latency, counted in cycles from the accepting edge to the done cycle:
  - load: RD_LAT+1
  - word store: 2
  - sub-word store: RD_LAT+2
- Back-to-back: req may be asserted in the cycle after done. There are no idle bubbles beyond the DONE cycle.
- mem_we is never asserted in IDLE, RD or DONE.
- Reset mid-transaction: the block returns to IDLE immediately and mem_we drops asynchronously. A partial read-modify-write is abandoned, and memory is unchanged unless the WR cycle had already completed.
- Extension: byte with sext=1 replicates bit 7; halfword replicates bit 15; sext is ignored for word loads.

Optional Feature:
- Macro: SCD_LSU_ALIGN_EXC_EN.
- Defined:
  - A misaligned request pulses misalign in the accepting cycle.
  - No memory access occurs; the FSM goes directly to DONE.
  - rdata is unchanged.
- Undefined:
  - misalign is tied 0.
  - Halfword addresses are forced to addr[1] alignment and word addresses to addr[1:0]=00.
  - The access proceeds normally.

Decomposition:
- Package scd_lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum IDLE, RD, WR, DONE
- Sub-module scd_lsu_lane: purely combinational lane extract/extend for loads and lane merge for stores, shared by the RD-capture and WR paths.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF. Load word addr=0x10 → rdata=0xDEADBEEF, done RD_LAT+1 cycles after acceptance, mem_we high exactly 1 cycle.
- Byte loads: memory word 0x80FF7F01 at 0x20.
  - lb addr=0x23 → 0xFFFFFF80
  - lbu addr=0x23 → 0x00000080
  - lb addr=0x21 → 0x0000007F
- Halfword read-modify-write: memory 0x11223344 at 0x30. sh addr=0x32, wdata=0x0000ABCD → memory 0xABCD3344. Done at RD_LAT+2 cycles.
- Byte read-modify-write: sb addr=0x31, wdata=0x000000EE on 0xABCD3344 → memory 0xABCDEE44.
- Misalign:
  - With macro: lw addr=0x42 → misalign pulse, done next cycle, no mem_we, rdata unchanged.
  - Without macro: same access reads word 0x40.
- Reset during RD of a sub-word store: clrn=0 → busy=0 and mem_we=0 immediately, memory word unchanged. A new request after release completes normally.

Source files
------------

// File: rtl/scd_lsu_pkg.sv
// scd_lsu_pkg: shared size encodings, FSM states and alignment helpers for the load/store unit.
package scd_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    // Reserved size 2'b11 falls through to the word rules everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? a[0] : a != 2'b00;
    endfunction

    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        return size == SZ_BYTE ? a : size == SZ_HALF ? {a[1], 1'b0} : 2'b00;
    endfunction

endpackage

// File: rtl/scd_lsu_lane.sv
// scd_lsu_lane: combinational little-endian lane extract/extend for loads and lane merge for stores.
module scd_lsu_lane
    import scd_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] ld,
    output logic [31:0] st
);

    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;

    assign sh   = {off, 3'b000};
    assign lane = 16'(word >> sh);

    always_comb begin
        ld   = size[1] ? word
             : size == SZ_HALF ? {{16{sext & lane[15]}}, lane}
             : {{24{sext & lane[7]}}, lane[7:0]};
        mask = (size == SZ_HALF ? 32'h0000_ffff : 32'h0000_00ff) << sh;
        st   = size[1] ? wdata : (word & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/scd_lsu.sv
// scd_lsu: byte/half/word load-store initiator over a word-only registered memory (RMW for sub-word stores).
// Define SCD_LSU_ALIGN_EXC_EN to trap misaligned requests instead of silently aligning them.
module scd_lsu
    import scd_lsu_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          misalign,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_datain,
    output logic          mem_we,
    input  logic [31:0]   mem_dataout
);

    localparam logic [2:0] LAST = 3'(RD_LAT - 1);

    state_t        state, nxt;
    logic [AW-3:0] addr_r;
    logic          wr_r, sext_r;
    logic [1:0]    size_r, off_r;
    logic [31:0]   wdata_r, ld, st;
    logic [2:0]    cnt;
    logic          accept, bad, last;

    assign accept = state == IDLE && req;
    assign last   = cnt == LAST;

`ifdef SCD_LSU_ALIGN_EXC_EN
    assign bad      = is_misaligned(size, addr[1:0]);
    assign misalign = accept && bad;
`else
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif

    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign mem_we = state == WR;
    // The address reaches memory in the accepting cycle so the read latency starts at that edge.
    assign mem_addr = {accept ? addr[AW-1:2] : addr_r, 2'b00};

    scd_lsu_lane u_lane (
        .word  (mem_dataout),
        .off   (off_r),
        .size  (size_r),
        .sext  (sext_r),
        .wdata (wdata_r),
        .ld    (ld),
        .st    (st)
    );

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) state <= IDLE;
        else       state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !req ? IDLE : bad ? DONE : (wr && size[1]) ? WR : RD;
            RD:      nxt = !last ? RD : wr_r ? WR : DONE;
            WR:      nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            addr_r     <= '0;
            wr_r       <= 1'b0;
            size_r     <= 2'b00;
            sext_r     <= 1'b0;
            off_r      <= 2'b00;
            wdata_r    <= '0;
            cnt        <= '0;
            rdata      <= '0;
            mem_datain <= '0;
        end else begin
            if (accept) begin
                addr_r  <= addr[AW-1:2];
                wr_r    <= wr;
                size_r  <= size;
                sext_r  <= sext;
                off_r   <= lane_off(size, addr[1:0]);
                wdata_r <= wdata;
                cnt     <= '0;
                if (wr && size[1] && !bad) mem_datain <= wdata;
            end
            if (state == RD) begin
                cnt <= last ? 3'd0 : cnt + 3'd1;
                if (last && wr_r)  mem_datain <= st;
                if (last && !wr_r) rdata      <= ld;
            end
        end
    end

endmodule

// File: tb/tb_scd_lsu.sv
// tb_scd_lsu: randomized + directed bench for scd_lsu against a behavioural word-memory model.
module tb_scd_lsu;

    localparam int RD_LAT = 2;
    localparam int AW     = 32;
`ifdef SCD_LSU_ALIGN_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic          clk = 1'b0, clrn = 1'b0, req = 1'b0, wr = 1'b0, sext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic          busy, done, misalign, mem_we;
    logic [31:0]   rdata, mem_datain, mem_dataout;
    logic [AW-1:0] mem_addr;

    scd_lsu #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .clk(clk), .clrn(clrn), .req(req), .wr(wr), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misalign(misalign), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_we(mem_we), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
    endfunction

    // Word memory with RD_LAT cycles from a stable address to valid read data.
    logic [31:0] mem [64];
    logic [31:0] pipe [RD_LAT];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        pipe[0] <= mem[mem_addr[7:2]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        else if (mem_we) mem[mem_addr[7:2]] <= mem_datain;
    end
    assign mem_dataout = pipe[RD_LAT-1];

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(string name, logic got, logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_i(string name, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: transaction timing plus expected memory/rdata effects.
    logic [31:0] ref_mem [64];
    int          acc_cyc = -1, lat_m = 0;
    bit          m_st = 1'b0, m_ld = 1'b0, chk_en = 1'b0;
    logic [31:0] m_ld_val = '0, m_st_val = '0, m_waddr = '0, rdata_m = '0;

    function automatic bit mis_m(logic [1:0] sz, logic [31:0] a);
        return sz == 2'd0 ? 1'b0 : sz == 2'd1 ? (a % 2) != 0 : (a % 4) != 0;
    endfunction

    function automatic int eff_off(logic [1:0] sz, logic [31:0] a);
        int o;
        o = int'(a % 4);
        if (sz == 2'd1) o = o - (o % 2);
        else if (sz >= 2'd2) o = 0;
        return o;
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] sz, bit sx, int o);
        longint unsigned v, wv;
        wv = 64'(w);
        if (sz >= 2'd2) return w;
        if (sz == 2'd0) begin
            v = (wv >> (8 * o)) % 256;
            if (sx && v >= 128) v = v + 64'h0000_0000_ffff_ff00;
        end else begin
            v = (wv >> (8 * o)) % 65536;
            if (sx && v >= 32768) v = v + 64'h0000_0000_ffff_0000;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] store_val(logic [31:0] old, logic [1:0] sz, int o, logic [31:0] wd);
        logic [31:0] r;
        int n;
        if (sz >= 2'd2) return wd;
        r = old;
        n = sz == 2'd0 ? 1 : 2;
        for (int b = 0; b < n; b++) r[8*(o+b) +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        bit act, we_e;
        if (chk_en && clrn) begin
            act  = acc_cyc >= 0 && cyc >= acc_cyc && cyc <= acc_cyc + lat_m - 1;
            if (act && m_ld && cyc == acc_cyc + lat_m - 1) rdata_m = m_ld_val;
            we_e = act && m_st && cyc == acc_cyc + lat_m - 2;
            chk1("busy", busy, act);
            chk1("done", done, act && cyc == acc_cyc + lat_m - 1);
            chk1("mem_we", mem_we, we_e);
            chk1("misalign_idle", misalign, 1'b0);
            if (we_e) begin
                chk("wr_addr", mem_addr, m_waddr);
                chk("wr_data", mem_datain, m_st_val);
            end
            chk("rdata", rdata, rdata_m);
        end
    end

    task automatic do_op(bit w, logic [1:0] sz, bit sx, logic [31:0] a, logic [31:0] wd, output int lat_meas);
        bit mis;
        int o, idx;
        logic [31:0] nw;
        @(negedge clk);
        #2;
        wr = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        mis = EXC && mis_m(sz, a);
        o   = eff_off(sz, a);
        idx = int'((a >> 2) % 64);
        nw  = store_val(ref_mem[idx], sz, o, wd);
        m_st = w && !mis;
        m_ld = !w && !mis;
        m_ld_val = load_val(ref_mem[idx], sz, sx, o);
        m_st_val = nw;
        m_waddr  = a & ~32'h3;
        lat_m = mis ? 1 : !w ? RD_LAT + 1 : sz[1] ? 2 : RD_LAT + 2;
        #1 chk1("misalign", misalign, mis);
        @(posedge clk);
        #1 acc_cyc = cyc;
        lat_meas = -1;
        for (int k = 0; k < RD_LAT + 6; k++) begin
            @(negedge clk);
            if (done) begin
                lat_meas = cyc - acc_cyc + 1;
                break;
            end
        end
        req = 1'b0;
        if (lat_meas < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles of acceptance", RD_LAT + 6);
        end
        if (m_st) ref_mem[idx] = nw;
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int l;
        logic [31:0] held;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_datain", mem_datain, 32'h0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        @(negedge clk);
        mem_init = 1'b0;
        clrn = 1'b1;
        chk_en = 1'b1;

        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hdead_beef, l);
        chk_i("sw_latency", l, 2);
        do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, l);
        chk("lw_10", rdata, 32'hdead_beef);
        chk_i("lw_latency", l, RD_LAT + 1);

        do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h80ff_7f01, l);
        do_op(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, l);
        chk("lb_23", rdata, 32'hffff_ff80);
        do_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, l);
        chk("lbu_23", rdata, 32'h0000_0080);
        do_op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, l);
        chk("lb_21", rdata, 32'h0000_007f);

        do_op(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344, l);
        do_op(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_abcd, l);
        chk("sh_32_mem", mem[12], 32'habcd_3344);
        chk_i("sh_latency", l, RD_LAT + 2);
        do_op(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00ee, l);
        chk("sb_31_mem", mem[12], 32'habcd_ee44);
        do_op(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, l);
        chk("lh_32", rdata, 32'hffff_abcd);

        do_op(1'b1, 2'b10, 1'b0, 32'h40, 32'h5566_7788, l);
        do_op(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, l);
        held = rdata;
        chk("lbu_41", held, 32'h0000_0077);
        do_op(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, l);
        chk("lw_42", rdata, EXC ? 32'h0000_0077 : 32'h5566_7788);
        chk_i("lw_42_latency", l, EXC ? 1 : RD_LAT + 1);

        // Abandon a halfword read-modify-write while it is still reading.
        @(negedge clk);
        #2;
        wr = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h52; wdata = 32'h0000_1234; req = 1'b1;
        @(posedge clk);
        #1;
        clrn = 1'b0;
        req = 1'b0;
        acc_cyc = -1;
        rdata_m = '0;
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_mem_we", mem_we, 1'b0);
        chk("rst_mid_rdata", rdata, 32'h0);
        @(negedge clk);
        #2 clrn = 1'b1;
        do_op(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, l);
        chk("rst_mem_unchanged", mem[20], init_word(20));
        chk("rst_reload", rdata, init_word(20));

        for (int t = 0; t < 300; t++)
            do_op(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), 32'($urandom % 256), $urandom, l);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
